// File: rtl/symdec_pkg.sv
// symdec_pkg: shared types and helpers for the symbol decimator.
// Holds the FSM state type, DECIM bounds and the channel slice index helper.
package symdec_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } symdec_state_t;

   localparam int DECIM_MIN = 4;
   localparam int DECIM_MAX = 16;

   // LSB position of channel ch inside a packed multi-channel word
   function automatic int chan_lsb(
      input int ch,
      input int w
   );
      return ch * w;
   endfunction

   // The slip scheme relies on at least 4 samples per symbol
   function automatic bit decim_ok(input int d);
      return (d >= DECIM_MIN) && (d <= DECIM_MAX);
   endfunction

endpackage

// File: rtl/symdec_chan_slice.sv
// symdec_chan_slice: per-channel output register of the symbol decimator.
// With SYMDEC_AVG_EN defined it averages the current and previous sample.
module symdec_chan_slice
   import symdec_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              smp,
   input  logic              cap,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

`ifdef SYMDEC_AVG_EN
   logic [DATA_W-1:0] prev;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] avg;

   // Sign-extended sum; bits [DATA_W:1] are the arithmetic >>>1 truncated
   assign sum = {din[DATA_W-1], din} + {prev[DATA_W-1], prev};
   assign avg = sum[DATA_W:1];

   // Previous valid sample, cleared whenever the block is not running
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev <= '0;
      end else if (clr) begin
         prev <= '0;
      end else if (smp) begin
         prev <= din;
      end
   end

   // Output register loads the two-sample average at the sample point
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= '0;
      end else if (clr) begin
         dout <= '0;
      end else if (cap) begin
         dout <= avg;
      end
   end
`else
   // Output register loads the raw sample at the sample point
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= '0;
      end else if (clr) begin
         dout <= '0;
      end else if (cap) begin
         dout <= din;
      end
   end
`endif

endmodule

// File: rtl/symbol_decimator.sv
// symbol_decimator: multi-channel symbol-rate decimator with phase slip.
// Optional macro SYMDEC_AVG_EN enables two-sample averaging per channel.
module symbol_decimator
   import symdec_pkg::*;
#(
   parameter int DATA_W = 4,
   parameter int CH     = 2,
   parameter int DECIM  = 8,
   parameter int CNT_W  = $clog2(DECIM)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 in_valid,
   input  logic [CH*DATA_W-1:0] in_data,
   input  logic [CNT_W-1:0]     sample_phase,
   input  logic                 slip_early,
   input  logic                 slip_late,
   output logic [CH*DATA_W-1:0] out_data,
   output logic                 out_valid,
   output logic                 slip_busy
);

   localparam logic [CNT_W:0]   DEC_X  = (CNT_W+1)'(DECIM);
   localparam logic [CNT_W-1:0] PH_MAX = CNT_W'(DECIM-1);
   localparam logic [CNT_W:0]   STEP1  = (CNT_W+1)'(1);
   localparam logic [CNT_W:0]   STEP2  = (CNT_W+1)'(2);

   if (!decim_ok(DECIM)) begin : g_bad_decim
      $error("symbol_decimator: DECIM outside 4..16");
   end

   symdec_state_t     state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  phase_reg;
   logic [CNT_W-1:0]  phase_cl;
   logic              pend_e;
   logic              pend_l;
   logic              post;
   logic              hit;
   logic              run;
   logic              smp;
   logic              cap;
   logic              clr;
   logic              req_one;

   // Counter advance modulo DECIM by one or two samples
   function automatic logic [CNT_W-1:0] wrap(
      input logic [CNT_W-1:0] c,
      input logic [CNT_W:0]   step
   );
      logic [CNT_W:0] s;
      s = {1'b0, c} + step;
      if (s >= DEC_X) begin
         s = s - DEC_X;
      end
      return s[CNT_W-1:0];
   endfunction

   assign phase_cl  = ({1'b0, sample_phase} >= DEC_X) ?
                      PH_MAX : sample_phase;
   assign hit       = (cnt == phase_reg);
   assign run       = (state == RUN) && enable;
   assign smp       = run && in_valid;
   assign cap       = smp && hit;
   assign clr       = !run;
   assign req_one   = slip_early ^ slip_late;
   assign slip_busy = pend_e | pend_l;

   // Control FSM: phase capture, sample counter and slip bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         phase_reg <= '0;
         pend_e    <= 1'b0;
         pend_l    <= 1'b0;
         post      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               cnt       <= '0;
               pend_e    <= 1'b0;
               pend_l    <= 1'b0;
               post      <= 1'b0;
               phase_reg <= phase_cl;
               if (enable) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (!enable) begin
                  state  <= IDLE;
                  cnt    <= '0;
                  pend_e <= 1'b0;
                  pend_l <= 1'b0;
                  post   <= 1'b0;
               end else begin
                  if (in_valid) begin
                     out_valid <= hit;
                     post      <= hit;
                     if (post && pend_l) begin
                        pend_l <= 1'b0;
                     end else if (post && pend_e) begin
                        cnt    <= wrap(cnt, STEP2);
                        pend_e <= 1'b0;
                     end else begin
                        cnt <= wrap(cnt, STEP1);
                     end
                  end
                  if (!slip_busy && req_one) begin
                     pend_e <= slip_early;
                     pend_l <= slip_late;
                  end
               end
            end
         endcase
      end
   end

   for (genvar g = 0; g < CH; g++) begin : g_ch
      localparam int LSB = chan_lsb(g, DATA_W);

      symdec_chan_slice #(
         .DATA_W (DATA_W)
      ) u_slice (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (clr),
         .smp   (smp),
         .cap   (cap),
         .din   (in_data[LSB +: DATA_W]),
         .dout  (out_data[LSB +: DATA_W])
      );
   end

endmodule

// File: tb/tb_symbol_decimator.sv
// tb_symbol_decimator: directed bench with a symbol-level reference model.
// Also exercises SYMDEC_AVG_EN when the macro is defined.
module tb_symbol_decimator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       in_valid;
   logic [7:0] in_data;
   logic [3:0] sample_phase;
   logic       slip_early;
   logic       slip_late;
   logic [7:0] out_data;
   logic       out_valid;
   logic       slip_busy;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int sidx = 0;
   bit chk_on = 1'b0;

   logic [7:0] dut_o[$];
   int         dut_cyc[$];
   int         gaps[$];

   // model state: countdown to the next sample point, pending slip
   bit               m_run = 1'b0;
   int               m_phase = 0;
   int               m_left = 0;
   int               m_pend = 0;
   bit               m_post = 1'b0;
   logic [7:0]       m_out = '0;
   logic             m_ov = 1'b0;
   logic signed [3:0] m_prev [2] = '{4'sd0, 4'sd0};
   int               vcount = 0;
   int               last_v = 0;

   symbol_decimator #(
      .DATA_W (4),
      .CH     (2),
      .DECIM  (8),
      .CNT_W  (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .sample_phase (sample_phase),
      .slip_early   (slip_early),
      .slip_late    (slip_late),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .slip_busy    (slip_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // reference model: symbol period of 8 valid samples, +-1 on a slip
   always @(posedge clk or negedge rst_n) begin
      bit busy0;
      logic signed [3:0] x;
      int s;
      if (!rst_n) begin
         m_run = 1'b0;
         m_phase = 0;
         m_pend = 0;
         m_post = 1'b0;
         m_out = '0;
         m_ov = 1'b0;
         m_prev[0] = '0;
         m_prev[1] = '0;
      end else begin
         m_ov = 1'b0;
         busy0 = (m_pend != 0);
         if (!m_run) begin
            m_phase = (sample_phase > 4'd7) ? 7 : int'(sample_phase);
            m_out = '0;
            m_pend = 0;
            m_prev[0] = '0;
            m_prev[1] = '0;
            if (enable) begin
               m_run = 1'b1;
               m_left = m_phase + 1;
               m_post = 1'b0;
               vcount = 0;
               last_v = 0;
            end
         end else if (!enable) begin
            m_run = 1'b0;
            m_out = '0;
            m_pend = 0;
            m_prev[0] = '0;
            m_prev[1] = '0;
         end else begin
            if (in_valid) begin
               vcount++;
               m_left--;
               if (m_post && m_pend != 0) begin
                  m_left += m_pend;
                  m_pend = 0;
               end
               if (m_left == 0) begin
                  for (int c = 0; c < 2; c++) begin
                     x = in_data[c*4 +: 4];
`ifdef SYMDEC_AVG_EN
                     s = (int'(x) + int'(m_prev[c])) >>> 1;
`else
                     s = int'(x);
`endif
                     m_out[c*4 +: 4] = 4'(s);
                  end
                  m_ov = 1'b1;
                  m_left = 8;
                  m_post = 1'b1;
                  gaps.push_back(vcount - last_v);
                  last_v = vcount;
               end else begin
                  m_post = 1'b0;
               end
               m_prev[0] = in_data[3:0];
               m_prev[1] = in_data[7:4];
            end
            if (!busy0 && (slip_early ^ slip_late)) begin
               m_pend = slip_early ? -1 : 1;
            end
         end
      end
   end

   // cycle compare of all outputs against the model
   always @(negedge clk) begin
      if (chk_on) begin
         total++;
         if ({out_valid, slip_busy, out_data} !==
             {m_ov, (m_pend != 0), m_out}) begin
            bad++;
            $display("FAIL cycle %0d: got v=%b b=%b d=%h want v=%b b=%b d=%h",
                     cyc, out_valid, slip_busy, out_data,
                     m_ov, (m_pend != 0), m_out);
         end
         if (out_valid === 1'b1) begin
            dut_o.push_back(out_data);
            dut_cyc.push_back(cyc);
         end
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic cyc1(input logic v, input logic [7:0] d,
                       input logic e, input logic l);
      in_valid = v;
      in_data = d;
      slip_early = e;
      slip_late = l;
      @(posedge clk);
      #2;
   endtask

   task automatic run(input int n, input bit tog,
                      input int e_at, input int l_at);
      for (int i = 0; i < n; i++) begin
         logic v;
         logic [3:0] di;
         logic [3:0] dq;
         v = !tog || (i % 2 == 0);
         di = 4'(sidx % 8);
         dq = 4'(sidx * 3);
         cyc1(v, {dq, di}, v && (sidx == e_at), v && (sidx == l_at));
         if (v) sidx++;
      end
      in_valid = 1'b0;
      slip_early = 1'b0;
      slip_late = 1'b0;
   endtask

   task automatic restart(input logic [3:0] ph);
      enable = 1'b0;
      sample_phase = ph;
      cyc1(1'b0, 8'h00, 1'b0, 1'b0);
      enable = 1'b1;
      cyc1(1'b0, 8'h00, 1'b0, 1'b0);
      sidx = 0;
      dut_o.delete();
      dut_cyc.delete();
      gaps.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      enable = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      sample_phase = '0;
      slip_early = 1'b0;
      slip_late = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk_on = 1'b1;
      check("rst_data", int'(out_data), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_busy", int'(slip_busy), 0);
      rst_n = 1'b1;
      cyc1(1'b0, 8'h00, 1'b0, 1'b0);

`ifndef SYMDEC_AVG_EN
      // ramp, phase 1: I=1, Q=3 at first symbol, period 8
      restart(4'd1);
      run(40, 1'b0, -1, -1);
      check("ramp_nout", dut_o.size(), 5);
      check("ramp_i0", int'(dut_o[0][3:0]), 1);
      check("ramp_q0", int'(dut_o[0][7:4]), 3);
      check("ramp_i4", int'(dut_o[4][3:0]), 1);
      check("ramp_q1", int'(dut_o[1][7:4]), 11);
      check("ramp_gap", gaps[1], 8);

      // phase sweep: 0, 7 and 9 (clamps to 7)
      restart(4'd0);
      run(17, 1'b0, -1, -1);
      check("ph0_i", int'(dut_o[1][3:0]), 0);
      restart(4'd7);
      run(17, 1'b0, -1, -1);
      check("ph7_i", int'(dut_o[0][3:0]), 7);
      restart(4'd9);
      run(17, 1'b0, -1, -1);
      check("ph9_i", int'(dut_o[1][3:0]), 7);
      check("ph9_gap0", gaps[0], 8);

      // early slip after the first symbol
      restart(4'd1);
      run(30, 1'b0, 1, -1);
      check("early_gap1", gaps[1], 7);
      check("early_gap2", gaps[2], 8);
      check("early_i1", int'(dut_o[1][3:0]), 0);

      // late slip
      restart(4'd1);
      run(30, 1'b0, -1, 1);
      check("late_gap1", gaps[1], 9);
      check("late_gap2", gaps[2], 8);
      check("late_i1", int'(dut_o[1][3:0]), 2);

      // simultaneous early+late ignored
      restart(4'd1);
      run(30, 1'b0, 1, 1);
      check("both_gap1", gaps[1], 8);
      check("both_i1", int'(dut_o[1][3:0]), 1);

      // late request while early pending is dropped
      restart(4'd1);
      run(30, 1'b0, 1, 2);
      check("drop_gap1", gaps[1], 7);

      // 50% valid: outputs every 16 clocks, same values
      restart(4'd1);
      run(40, 1'b1, -1, -1);
      check("tog_nout", dut_o.size(), 3);
      check("tog_i1", int'(dut_o[1][3:0]), 1);
      check("tog_dt", dut_cyc[1] - dut_cyc[0], 16);

      // enable drop at cnt=4, re-enable with phase 3
      restart(4'd1);
      run(4, 1'b0, -1, -1);
      check("drop_pre", int'(out_data), 8'h31);
      enable = 1'b0;
      cyc1(1'b1, 8'h55, 1'b0, 1'b0);
      check("drop_data", int'(out_data), 0);
      check("drop_valid", int'(out_valid), 0);
      restart(4'd3);
      run(8, 1'b0, -1, -1);
      check("reen_i", int'(dut_o[0][3:0]), 3);

      // asynchronous reset mid-symbol with a slip pending
      restart(4'd1);
      run(3, 1'b0, 2, -1);
      check("ar_busy_pre", int'(slip_busy), 1);
      check("ar_data_pre", int'(out_data), 8'h31);
      #1;
      rst_n = 1'b0;
      #1;
      check("ar_data", int'(out_data), 0);
      check("ar_valid", int'(out_valid), 0);
      check("ar_busy", int'(slip_busy), 0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #2;
`else
      // averaging: I -8 then 7 -> -1, Q 7 then 7 -> 7
      restart(4'd1);
      cyc1(1'b1, 8'h78, 1'b0, 1'b0);
      cyc1(1'b1, 8'h77, 1'b0, 1'b0);
      check("avg_out", int'(out_data), 8'h7F);
      run(30, 1'b0, 1, -1);
      check("avg_gap", gaps[2], 7);
      restart(4'd1);
      run(30, 1'b0, -1, 1);
      check("avg_late", gaps[1], 9);
`endif

      enable = 1'b0;
      run(3, 1'b0, -1, -1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/symbol_decimator.md
# symbol_decimator

Parametrised multi-channel symbol-rate decimator for the QAM16 receive path. It sits after the matched filter/slicer front end and before symbol demapping. It takes an oversampled stream of signed I/Q samples and emits one sample per symbol at a programmable phase. The phase can be slipped ±1 sample by timing recovery. It supersedes the fixed 4-bit, single-channel, phase-1 downsampler with external count.

## Interface
Parameters:
- DATA_W, 4, signed sample width per channel
- CH, 2, channel count (I, Q, ...)
- DECIM, 8, oversampling factor, legal range 4..16
- CNT_W, $clog2(DECIM), phase counter width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  block enable; low forces IDLE
- in_valid  in  1  one oversampled input sample present
- in_data  in  CH*DATA_W  packed signed samples, channel 0 in LSBs
- sample_phase  in  CNT_W  sampling phase; captured only in IDLE
- slip_early  in  1  one-cycle request to shorten next symbol by one sample
- slip_late  in  1  one-cycle request to lengthen next symbol by one sample
- out_data  out  CH*DATA_W  decimated symbol samples, registered
- out_valid  out  1  one-cycle strobe, out_data updated
- slip_busy  out  1  a slip is pending and not yet applied

## Operation
- State machine, 2 states:
  - IDLE: enable=0. cnt=0, pending flags cleared, out_data=0, out_valid=0. phase_reg<=sample_phase; values ≥DECIM clamp to DECIM-1.
  - RUN: entered on the first cycle with enable=1. enable=0 returns to IDLE on the next edge and clears everything as above.
- In RUN, action on each in_valid=1 cycle:
  - If cnt==phase_reg: out_data<=sampled value, out_valid<=1, post<=1.
  - Counter update: if post=1 and a slip is pending, apply it: late holds cnt, early adds 2 mod DECIM. Clear that pending flag and post. Otherwise cnt<=(cnt+1) mod DECIM.
  - Because the slip is applied on the sample after the sample point, and DECIM≥4, a slip never skips or repeats phase_reg.
- Slip requests:
  - slip_early/slip_late set pending_early/pending_late; only one may be pending.
  - Requests arriving while one is pending are dropped.
  - Simultaneous early and late in one cycle are both ignored.
- in_valid=0 cycles: cnt, post and out_data hold; out_valid=0.
- Arithmetic: sample path is pass-through per channel, no widening.

## Timing
- Reset values: out_data=0, out_valid=0, slip_busy=0, cnt=0, state=IDLE, phase_reg=0.
- Latency: out_valid asserts one cycle after the edge capturing the in_valid sample with cnt==phase_reg.
- Without slips, symbol period is exactly DECIM valid samples.
  - Early slip: that period is DECIM-1.
  - Late slip: that period is DECIM+1.
- slip_busy is combinational: pending_early|pending_late. It falls on the cycle after the slip is applied.
- enable deassert mid-symbol: no partial output; out_data=0 on the next edge.

## Configuration
- SYMDEC_AVG_EN defined:
  - Each channel keeps the previous valid sample.
  - Output is (x[n]+x[n-1])>>>1, computed DATA_W+1 wide with an arithmetic shift and truncated to DATA_W.
  - The previous-sample register clears in IDLE.
- SYMDEC_AVG_EN undefined: output is the raw sample at cnt==phase_reg; no extra registers.

## Structure
- Package symdec_pkg: state enum (IDLE, RUN), DECIM legality constants, and the channel-slice helper for unpacking in_data.
- Sub-module symdec_chan_slice, instantiated CH times:
  - Holds the output register and, under SYMDEC_AVG_EN, the previous-sample register and adder.
  - Takes a shared capture strobe.
- Top level holds the FSM, counter, phase_reg and slip logic.

## Test plan
- DECIM=8, phase=1, continuous valid, I ramp 0..7 repeating → out_valid every 8 cycles, out I=1 each time; I/Q channels independent.
- Phase sweep with phase=0, 7, 9 → samples at cnt 0, 7, 7 (9 clamps to 7).
- Early slip after a sample → next out_valid 7 valid samples later, then 8. Late slip → 9 then 8. Simultaneous early+late → no change.
- in_valid toggling 50% → outputs every 16 clocks, identical values to the continuous case.
- enable drop at cnt=4 → out_data=0 next cycle, no out_valid. Re-enable with phase=3 → first output at cnt=3. rst_n asserted mid-symbol → all outputs 0 asynchronously.
- SYMDEC_AVG_EN, inputs −8 then 7 at the sample point → out=−1; inputs 7,7 → 7.
